// File: rtl/ring_coder_n.sv
// ring_coder_n: WIDTH-bit shift counter usable as a phase/slot sequencer.
//   MODE = 0 : one-hot ring, WIDTH states, CODE = index of the set bit.
//   MODE = 1 : Johnson (twisted ring), 2*WIDTH states, CODE = position in sequence.
// Illegal states are flagged on VALID and cleared to Q = 1 by the next enabled edge.
//
// Ports:
//   CLK      in   clock, rising edge
//   RST_N    in   asynchronous active-low reset (Q = 1, WRAP = 0)
//   EN       in   step enable
//   DIR      in   0 = up (bit i -> bit i+1), 1 = down
//   MODE     in   0 = ring, 1 = Johnson
//   LOAD     in   synchronous parallel load, overrides EN
//   LOAD_VAL in   value written to Q on LOAD (taken as-is, even if illegal)
//   Q        out  state register
//   CODE     out  binary position of Q (0 when illegal), combinational
//   VALID    out  Q is legal for the current MODE, combinational
//   WRAP     out  registered one-cycle pulse after a terminal-count wrap
module ring_coder_n #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CW    = $clog2(2 * WIDTH)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN,
  input  logic             DIR,
  input  logic             MODE,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VAL,
  output logic [WIDTH-1:0] Q,
  output logic [CW-1:0]    CODE,
  output logic             VALID,
  output logic             WRAP
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;

  logic [CW-1:0]    pop;
  logic [WIDTH-1:0] low_mask;   // pop ones anchored at bit 0
  logic [WIDTH-1:0] high_mask;  // pop ones anchored at bit WIDTH-1
  logic [CW-1:0]    code_ring;
  logic [CW-1:0]    code_john;
  logic [CW-1:0]    code_raw;
  logic [CW-1:0]    last_code;
  logic             valid;

  // Population count and the two legal Johnson shapes for that count.
  always_comb begin
    pop = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      pop = pop + CW'(q_q[i]);
    end
    for (int i = 0; i < int'(WIDTH); i++) begin
      low_mask[i]  = (i < int'(pop));
      high_mask[i] = (i >= int'(WIDTH) - int'(pop));
    end
  end

  always_comb begin
    code_ring = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (q_q[i]) code_ring = CW'(i);
    end
    // Ones growing from bit 0 count up from 0; ones draining toward the top
    // are the second half of the sequence. 2*WIDTH may truncate to 0 at the
    // top of the range, which is still correct modulo 2^CW.
    if (q_q[0]) begin
      code_john = pop;
    end else if (q_q == '0) begin
      code_john = '0;
    end else begin
      code_john = CW'(2 * WIDTH) - pop;
    end
  end

  always_comb begin
    if (MODE) begin
      valid     = (q_q == low_mask) || (q_q == high_mask);
      code_raw  = code_john;
      last_code = CW'(2 * WIDTH - 1);
    end else begin
      valid     = (pop == CW'(1));
      code_raw  = code_ring;
      last_code = CW'(WIDTH - 1);
    end
  end

  // Next state: load, then recovery, then step, then hold.
  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (LOAD) begin
      q_d = LOAD_VAL;
    end else if (EN && !valid) begin
      q_d = WIDTH'(1);
    end else if (EN) begin
      case ({MODE, DIR})
        2'b00:   q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        2'b01:   q_d = {q_q[0], q_q[WIDTH-1:1]};
        2'b10:   q_d = {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
        default: q_d = {~q_q[0], q_q[WIDTH-1:1]};
      endcase
      // From a legal state the terminal code always steps to the opposite end.
      wrap_d = DIR ? (code_raw == '0) : (code_raw == last_code);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      q_q    <= WIDTH'(1);
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign Q     = q_q;
  assign VALID = valid;
  assign CODE  = valid ? code_raw : '0;
  assign WRAP  = wrap_q;

endmodule

// File: tb/tb_ring_coder_n.sv
// Directed, table-driven bench for ring_coder_n at WIDTH = 4.
module tb_ring_coder_n;

  localparam int unsigned W  = 4;
  localparam int unsigned CW = $clog2(2 * W);

  logic          clk;
  logic          rst_n;
  logic          en, dir, mode, load;
  logic [W-1:0]  load_val;
  logic [W-1:0]  q;
  logic [CW-1:0] code;
  logic          valid, wrap;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic          load;
    logic [W-1:0]  lv;
    logic          en;
    logic          dir;
    logic          mode;
    logic [W-1:0]  q;
    logic [CW-1:0] code;
    logic          valid;
    logic          wrap;
  } vec_t;

  vec_t vecs[$];

  ring_coder_n #(.WIDTH(W)) dut (
    .CLK      (clk),
    .RST_N    (rst_n),
    .EN       (en),
    .DIR      (dir),
    .MODE     (mode),
    .LOAD     (load),
    .LOAD_VAL (load_val),
    .Q        (q),
    .CODE     (code),
    .VALID    (valid),
    .WRAP     (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int idx, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic ld, input logic [W-1:0] lv, input logic e, input logic d,
                     input logic m, input logic [W-1:0] eq, input logic [CW-1:0] ec,
                     input logic ev, input logic ew);
    vec_t v;
    v.load = ld; v.lv = lv; v.en = e; v.dir = d; v.mode = m;
    v.q = eq; v.code = ec; v.valid = ev; v.wrap = ew;
    vecs.push_back(v);
  endtask

  task automatic check_all(input int idx, input logic [W-1:0] eq, input logic [CW-1:0] ec,
                           input logic ev, input logic ew);
    check("q", idx, 64'(q), 64'(eq));
    check("code", idx, 64'(code), 64'(ec));
    check("valid", idx, 64'(valid), 64'(ev));
    check("wrap", idx, 64'(wrap), 64'(ew));
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; dir = 1'b0; mode = 1'b0; load = 1'b0; load_val = '0;

    //   ld lv       en dir mode  q        code valid wrap
    // Ring up, 8 edges from reset.
    add(0, 4'b0000, 1, 0, 0, 4'b0010, 3'd1, 1, 0);
    add(0, 4'b0000, 1, 0, 0, 4'b0100, 3'd2, 1, 0);
    add(0, 4'b0000, 1, 0, 0, 4'b1000, 3'd3, 1, 0);
    add(0, 4'b0000, 1, 0, 0, 4'b0001, 3'd0, 1, 1);
    add(0, 4'b0000, 1, 0, 0, 4'b0010, 3'd1, 1, 0);
    add(0, 4'b0000, 1, 0, 0, 4'b0100, 3'd2, 1, 0);
    add(0, 4'b0000, 1, 0, 0, 4'b1000, 3'd3, 1, 0);
    add(0, 4'b0000, 1, 0, 0, 4'b0001, 3'd0, 1, 1);
    // Johnson up from 0001, 9 edges.
    add(0, 4'b0000, 1, 0, 1, 4'b0011, 3'd2, 1, 0);
    add(0, 4'b0000, 1, 0, 1, 4'b0111, 3'd3, 1, 0);
    add(0, 4'b0000, 1, 0, 1, 4'b1111, 3'd4, 1, 0);
    add(0, 4'b0000, 1, 0, 1, 4'b1110, 3'd5, 1, 0);
    add(0, 4'b0000, 1, 0, 1, 4'b1100, 3'd6, 1, 0);
    add(0, 4'b0000, 1, 0, 1, 4'b1000, 3'd7, 1, 0);
    add(0, 4'b0000, 1, 0, 1, 4'b0000, 3'd0, 1, 1);
    add(0, 4'b0000, 1, 0, 1, 4'b0001, 3'd1, 1, 0);
    add(0, 4'b0000, 1, 0, 1, 4'b0011, 3'd2, 1, 0);
    // Hold, then 0011 seen in ring mode is illegal; one enabled edge recovers.
    add(0, 4'b0000, 0, 0, 1, 4'b0011, 3'd2, 1, 0);
    add(0, 4'b0000, 0, 0, 0, 4'b0011, 3'd0, 0, 0);
    add(0, 4'b0000, 1, 0, 0, 4'b0001, 3'd0, 1, 0);
    // Ring down wraps 0001 -> 1000, then DIR back to up.
    add(0, 4'b0000, 1, 1, 0, 4'b1000, 3'd3, 1, 1);
    add(0, 4'b0000, 1, 1, 0, 4'b0100, 3'd2, 1, 0);
    add(0, 4'b0000, 1, 0, 0, 4'b1000, 3'd3, 1, 0);
    // Illegal load with EN (load wins), then recovery.
    add(1, 4'b0110, 1, 0, 0, 4'b0110, 3'd0, 0, 0);
    add(0, 4'b0000, 1, 0, 0, 4'b0001, 3'd0, 1, 0);
    // Ring 0100 then MODE switch to Johnson: illegal, recovers to 0001.
    add(1, 4'b0100, 0, 0, 0, 4'b0100, 3'd2, 1, 0);
    add(0, 4'b0000, 0, 0, 1, 4'b0100, 3'd0, 0, 0);
    add(0, 4'b0000, 1, 0, 1, 4'b0001, 3'd1, 1, 0);
    // Johnson down, wrap 0000 -> 1000.
    add(0, 4'b0000, 1, 1, 1, 4'b0000, 3'd0, 1, 0);
    add(0, 4'b0000, 1, 1, 1, 4'b1000, 3'd7, 1, 1);
    add(0, 4'b0000, 1, 1, 1, 4'b1100, 3'd6, 1, 0);
    // Load with EN from a terminal-adjacent state: no step, no wrap.
    add(1, 4'b1111, 1, 1, 1, 4'b1111, 3'd4, 1, 0);

    // Reset state, checked while RST_N is still low.
    repeat (2) @(negedge clk);
    check_all(-1, 4'b0001, 3'd0, 1'b1, 1'b0);
    mode = 1'b1;
    #1;
    check("code_rst_johnson", -1, 64'(code), 64'd1);
    mode = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      load = vecs[i].load; load_val = vecs[i].lv; en = vecs[i].en;
      dir = vecs[i].dir; mode = vecs[i].mode;
      @(posedge clk);
      #1;
      check_all(i, vecs[i].q, vecs[i].code, vecs[i].valid, vecs[i].wrap);
      @(negedge clk);
    end

    // Asynchronous reset mid-cycle while WRAP is high.
    load = 1'b1; load_val = 4'b0001; en = 1'b0; dir = 1'b0; mode = 1'b0;
    @(negedge clk);
    load = 1'b0; en = 1'b1; dir = 1'b1;
    @(posedge clk);
    #1;
    check_all(100, 4'b1000, 3'd3, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all(101, 4'b0001, 3'd0, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check("q_hold", 102 + k, 64'(q), 64'(4'b0001));
      check("wrap_hold", 102 + k, 64'(wrap), 64'd0);
      @(negedge clk);
    end
    // First enabled edge steps from the reset state.
    en = 1'b1; dir = 1'b0;
    @(posedge clk);
    #1;
    check_all(110, 4'b0010, 3'd1, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ring_coder_n.md
# ring_coder_n

- Parametrised successor to the team's fixed 4-bit ring counter and 2-bit one-hot coder.
- A WIDTH-bit shift counter with two modes: one-hot ring (WIDTH states) and Johnson/twisted-ring (2·WIDTH states).
- Runs up or down under enable, supports parallel load, and produces a binary position code, a legality flag and a wrap pulse.
- Detects and self-recovers from illegal states. Used as the phase/slot sequencer feeding downstream decode logic.

## Interface
Parameters:
- WIDTH, 4: number of state flip-flops; legal range 2..64.
- CW, $clog2(2*WIDTH): width of CODE (derived; do not override).

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- EN  in  1  step enable; one step per rising edge while high.
- DIR  in  1  0 = up (bit i moves to bit i+1), 1 = down.
- MODE  in  1  0 = ring, 1 = Johnson.
- LOAD  in  1  synchronous parallel load; overrides EN.
- LOAD_VAL  in  WIDTH  value written to Q on LOAD.
- Q  out  WIDTH  state register.
- CODE  out  CW  binary position of Q (combinational from Q and MODE).
- VALID  out  1  Q is a legal state for the current MODE (combinational).
- WRAP  out  1  registered one-cycle pulse on terminal-count wrap.

## Operation
- Reset (RST_N low, asynchronous): Q = 1 (only bit 0 set), WRAP = 0. Resulting outputs: CODE = 0 in ring mode, 1 in Johnson mode; VALID = 1.
- Per-edge priority: LOAD, then recovery, then step, then hold.
  - LOAD = 1: Q <= LOAD_VAL, loaded unchanged even if illegal.
  - Else EN = 1 and VALID = 0: Q <= 1 (recovery); WRAP <= 0.
  - Else EN = 1: step as defined below.
  - Else: hold; WRAP <= 0.
- Ring step:
  - up: Q <= {Q[W-2:0], Q[W-1]}
  - down: Q <= {Q[0], Q[W-1:1]}
- Johnson step:
  - up: Q <= {Q[W-2:0], ~Q[W-1]}
  - down: Q <= {~Q[0], Q[W-1:1]}
- Ring legality and CODE:
  - VALID = Q has exactly one bit set.
  - CODE = index of the set bit.
- Johnson legality and CODE:
  - VALID = Q is contiguous ones anchored at bit 0 (including 0) or contiguous ones anchored at bit W-1.
  - Let P = popcount(Q). CODE = P if Q[0] = 1; 0 if Q = 0; otherwise 2W−P.
  - Example, W = 4, up: 0000→0, 0001→1, 0011→2, 0111→3, 1111→4, 1110→5, 1100→6, 1000→7, then 0000.
- Illegal state: CODE forced to 0, VALID = 0.
- WRAP is set to 1 for the cycle after an enabled step that moves from the terminal code to the opposite end:
  - up: last code → 0
  - down: 0 → last code
  - last code = W−1 (ring) or 2W−1 (Johnson).
- WRAP is 0 after any other step, after LOAD, and after recovery.
- MODE and DIR are sampled at each edge and may change at any time. No reset is needed. If Q is illegal in the new MODE, VALID drops and the next enabled edge recovers.

## Timing
- Step latency: one edge. Q, CODE and VALID reflect the step immediately after the edge.
- WRAP asserts in the same cycle as the wrapped Q and lasts exactly one cycle per wrap. With continuous EN it pulses every W (ring) or 2W (Johnson) cycles.
- LOAD and EN together: load wins, no step, WRAP = 0.
- RST_N asserted mid-operation: Q = 1 and WRAP = 0 immediately, with no clock needed. The first edge after deassertion with EN = 1 steps from the reset state.
- Recovery costs exactly one enabled edge: illegal → Q = 1 → normal stepping.
- CODE and VALID have no registers: combinational path from Q and MODE only.

## Test plan
- W = 4, ring, up, EN = 1 from reset for 8 edges: Q = 0010, 0100, 1000, 0001, 0010…; CODE = 1, 2, 3, 0, 1…; WRAP high only while CODE = 0 after the 1000 step.
- W = 4, Johnson, up, 9 edges: CODE sequence 2, 3, 4, 5, 6, 7, 0, 1, 2; Q for CODE 5 = 1110; a single WRAP pulse coincides with CODE 0.
- W = 4, ring, down from reset: Q = 1000 with CODE = 3 and WRAP = 1, then Q = 0100 with WRAP = 0. Toggle DIR to 0 mid-run: the next step moves up.
- LOAD_VAL = 0110 in ring mode, then EN: VALID = 0 and CODE = 0 after load, then Q = 0001 with VALID = 1. LOAD and EN asserted together: Q = LOAD_VAL, no step.
- Switch MODE from ring (Q = 0100) to Johnson: VALID = 0; the next EN edge gives Q = 0001 and CODE = 1.
- Assert RST_N low asynchronously mid-cycle while Q = 1000 and WRAP = 1: Q = 0001 and WRAP = 0 before the next edge. Hold EN = 0 for 5 edges: Q is unchanged.
